// File: rtl/cell_edit_pkg.sv
// Shared types and constants for the keypad cell editor.
package cell_edit_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_COLOR = 2'd1,
    COMMIT     = 2'd2
  } state_t;

  localparam logic [3:0] KEY_CANCEL = 4'hF;
  localparam logic [3:0] COLOR_MAX  = 4'h7;

  localparam int AW_DEFAULT = 4;
  localparam int DW_DEFAULT = 3;

  // True when the key code names one of the eight RGB colours.
  function automatic logic is_color_key(input logic [3:0] code);
    return (code <= COLOR_MAX);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Free-running wait counter; flags the last allowed cycle of the colour wait.
module timeout_counter #(
  parameter int TIMEOUT_CYC = 250000000,
  parameter int TW          = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] ONE        = TW'(1);

  logic [TW-1:0] count_r;

  // Count cycles spent waiting; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST_COUNT);

endmodule

// File: rtl/cell_edit_ctrl.sv
// Two-key editor: position key then colour key yields one bank write.
module cell_edit_ctrl
  import cell_edit_pkg::*;
#(
  parameter int AW          = AW_DEFAULT,
  parameter int DW          = DW_DEFAULT,
  parameter int TIMEOUT_CYC = 250000000,
  parameter int TW          = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_en,
  output logic [AW-1:0] cur_pos,
  output logic          busy,
  output logic          abort
);

  state_t state_r;
  logic   cnt_clear_s;
  logic   cnt_enable_s;
  logic   expired_s;

  // A position key restarts the wait; the counter only runs while waiting.
  assign cnt_clear_s  = (state_r == IDLE) && key_valid;
  assign cnt_enable_s = (state_r == WAIT_COLOR);

  timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TW         (TW)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear_s),
    .enable (cnt_enable_s),
    .expired(expired_s)
  );

  // Sequence FSM with every output registered; colour key beats timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      wr_addr <= '0;
      wr_data <= '0;
      cur_pos <= '0;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
      abort   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      abort <= 1'b0;
      case (state_r)
        IDLE: begin
          if (key_valid) begin
            wr_addr <= AW'(key_code);
            cur_pos <= AW'(key_code);
            busy    <= 1'b1;
            state_r <= WAIT_COLOR;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        WAIT_COLOR: begin
          if (key_valid && is_color_key(key_code)) begin
            wr_data <= DW'(key_code[2:0]);
            wr_en   <= 1'b1;
            busy    <= 1'b0;
            state_r <= COMMIT;
          end else if (key_valid && (key_code == KEY_CANCEL)) begin
            abort   <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (expired_s) begin
            abort   <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            busy    <= 1'b1;
            state_r <= WAIT_COLOR;
          end
        end
        COMMIT: begin
          // Write strobe already issued; keys arriving now are dropped.
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cell_edit_ctrl.md
# cell_edit_ctrl

Keypad-driven editing controller between the keypad scanner and the colour register bank. It turns a two-key sequence, a cell position key followed by a colour key, into a single-cycle write into the bank's write port. It also exposes the selected cursor position and an abort indication for the seven-segment display path.

## Interface
Parameters:
- `AW`, 4: address width; 16 cells.
- `DW`, 3: colour width; RGB, 1 bit each.
- `TIMEOUT_CYC`, 250000000: cycles allowed between position key and colour key (5 s at 50 MHz).
- `TW`, 28: timeout counter width; must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-low reset.
- `key_valid`  in  1  one-cycle pulse from the scanner; exactly one pulse per key press.
- `key_code`  in  4  key value, valid only while `key_valid`=1.
- `wr_addr`  out  AW  bank write address.
- `wr_data`  out  DW  bank write colour.
- `wr_en`  out  1  one-cycle bank write strobe.
- `cur_pos`  out  AW  last selected position, for the display.
- `busy`  out  1  high while waiting for a colour key.
- `abort`  out  1  one-cycle pulse on cancel or timeout.

## Operation
- The FSM has three states: `IDLE`, `WAIT_COLOR`, `COMMIT`.
- **IDLE**
  - On `key_valid`: latch `key_code` into `wr_addr` and `cur_pos`, clear the timeout counter, go to `WAIT_COLOR`.
  - Every code 0x0–0xF is a legal position.
- **WAIT_COLOR**
  - The timeout counter increments by 1 every cycle.
  - `key_valid` with `key_code` 0x0–0x7: latch `key_code[2:0]` into `wr_data`, go to `COMMIT`.
  - `key_valid` with `key_code` 0xF (cancel): pulse `abort`, go to `IDLE`.
  - `key_valid` with `key_code` 0x8–0xE: ignored; stay, counter keeps running.
  - Counter reaching `TIMEOUT_CYC`-1 without a qualifying key: pulse `abort`, go to `IDLE`.
- **COMMIT**
  - `wr_en`=1 for exactly this cycle, then go to `IDLE`.
  - Any `key_valid` in this state is dropped.
- `busy` = (state == `WAIT_COLOR`).
- On cancel or timeout, `wr_addr` and `wr_data` keep their previous values. No write is issued.
- `cur_pos` changes only on a new position key in `IDLE`.

## Timing
- Reset values, applied at the first rising edge with `rst`=0:
  - state `IDLE`, counter 0.
  - `wr_addr`=0, `wr_data`=0, `cur_pos`=0.
  - `wr_en`=0, `busy`=0, `abort`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Position key at edge N: `busy`=1 and `cur_pos` updated after edge N.
- Colour key at edge N: `wr_en`=1 during cycle N+1, with `wr_addr`/`wr_data` already stable. `busy`=0 from edge N.
- `wr_addr` and `wr_data` are held unchanged through and after the `wr_en` cycle.
- Cancel key at edge N: `abort`=1 during cycle N+1 only.
- Timeout: `abort` asserts exactly `TIMEOUT_CYC` cycles after the position key edge.
- Simultaneous events: a colour key in the same cycle the timeout expires wins. The write happens and there is no `abort`.
- Reset mid-operation, in `WAIT_COLOR` or `COMMIT`: returns to `IDLE`. `wr_en` is 0 in the cycle after the reset edge. No partial write is ever issued.
- Back-to-back sequences: a new position key is accepted in the cycle immediately after `COMMIT`.
- Minimum sequence length is 3 cycles.

## Structure
- Shared package `cell_edit_pkg`:
  - state enum encoding (2 bits).
  - `KEY_CANCEL` = 4'hF.
  - `COLOR_MAX` = 4'h7.
  - default `AW`/`DW` values.
- Sub-module `timeout_counter`:
  - ports: clk, rst, clear, enable, expired.
  - `TW`-bit counter; `expired` is combinational at count == `TIMEOUT_CYC`-1.
  - instantiated once.
- Everything else, FSM and output registers, lives in `cell_edit_ctrl`.
- Integration: `wr_addr`/`wr_en` drive the bank's `addrW`/`RegWrite`, `wr_data` drives its write-data input, and `cur_pos` drives the display's `posicion`.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with random `key_valid` activity -> all outputs 0, `wr_en` never asserted.
- **Normal write:** key 0xA, then 5 cycles later key 0x5 -> exactly one `wr_en` pulse, one cycle after the colour key, with `wr_addr`=0xA, `wr_data`=3'b101, `cur_pos`=0xA.
- **Cancel and ignore:** key 0x3, then 0x9, then 0xF -> 0x9 ignored (`busy` stays 1), `abort` pulses once, no `wr_en`, `wr_addr` retains 0x3.
- **Timeout:** `TIMEOUT_CYC`=20, key 0x7, then silence -> `abort` exactly 20 cycles after the key. Repeat with colour key 0x2 on cycle 19 -> write, no `abort`.
- **Reset mid-operation:** key 0x4, then `rst`=0 on the same edge as colour key 0x1 -> no `wr_en`, state `IDLE`, outputs at reset values.
- **Back-to-back:** sequences (0x0,0x7), (0xF,0x0), (0x5,0x3) with minimum spacing -> three `wr_en` pulses with matching addr/data. Key 0xF is accepted as a position in `IDLE`, not treated as cancel.
